enc_swc: RTL
============

Name: enc_swc

Overview:
- RV32I instruction encoder: the inverse of the dec_swc decoder.
- Accepts an operation index plus register and immediate fields over a valid/ready handshake, then assembles the 32-bit instruction word.
- Queues encoded words in a small FIFO toward a downstream consumer: instruction memory loader, fetch-side test stimulus, or ifu model.
- Flags illegal operations and out-of-range immediates.

Parameters:
DEPTH, 2, output FIFO entries (power of two, >=2)
CNT_W, 16, width of accepted-instruction counter

Ports:
hclk  input  1  clock, rising edge
hrst  input  1  asynchronous active-high reset
enc_valid  input  1  request valid
enc_ready  output  1  encoder can accept (FIFO not full)
enc_op  input  6  op index: 0 lui,1 auipc,2 jal,3 jalr,4 beq,5 bne,6 blt,7 bge,8 bltu,9 bgeu,10 lb,11 lh,12 lw,13 lbu,14 lhu,15 sb,16 sh,17 sw,18 addi,19 slti,20 sltiu,21 xori,22 ori,23 andi,24 slli,25 srli,26 srai,27 add,28 sub,29 sll,30 slt,31 sltu,32 xor,33 srl,34 sra,35 or,36 and,37 fence,38 fence_i,39 ecall,40 ebreak,41 csrrw,42 csrrs,43 csrrc,44 csrrwi,45 csrrsi,46 csrrci; 47-63 illegal
enc_rd  input  5  destination register
enc_rs1  input  5  source 1 (zimm for ops 44-46)
enc_rs2  input  5  source 2
enc_imm  input  32  signed byte offset/immediate; U-type value in [31:12]; shamt in [4:0]; CSR address or fence fm/pred/succ in [11:0]
inst_out  output  32  encoded instruction at FIFO head
inst_err  output  1  error flag for head entry
inst_valid  output  1  FIFO non-empty
inst_ready  input  1  consumer accepts head
enc_count  output  CNT_W  accepted-request counter

Behaviour:
- Reset (hrst high, async):
  - FIFO pointers and occupancy cleared.
  - inst_valid=0, inst_out=0, inst_err=0, enc_count=0.
  - enc_ready=0 while hrst is asserted, and 1 in the first cycle after release.
- Accept: enc_valid & enc_ready at a rising edge.
  - Encodes combinationally from the inputs and pushes {err, word} into the FIFO.
  - enc_count increments, wrapping at 2^CNT_W.
- Latency:
  - Word accepted at edge N is visible at the head with inst_valid=1 after edge N when the FIFO was empty.
  - No combinational path from enc_* to inst_*.
- Pop: inst_valid & inst_ready at an edge advances the head. inst_out and inst_err hold while inst_valid & !inst_ready.
- enc_ready = !full, registered from occupancy. When full, a same-cycle pop does not enable a push; enc_ready rises the cycle after.
- Simultaneous push and pop when neither empty nor full: occupancy unchanged, order preserved. Pointers wrap modulo DEPTH.
- Encoding follows standard RV32I formats:
  - opcodes: LUI 0x37, AUIPC 0x17, JAL 0x6F, JALR 0x67, BRANCH 0x63, LOAD 0x03, STORE 0x23, OP-IMM 0x13, OP 0x33, MISC-MEM 0x0F, SYSTEM 0x73.
  - funct7=0x20 for sub, sra and srai.
  - fence_i = fixed 0x0000100F; ecall = 0x00000073; ebreak = 0x00100073.
  - Fields not used by a format are ignored (e.g. enc_rs2 for I-type).
- Illegal op (47-63): entry pushed with inst_err=1 and word=0x00000000. It is still counted and still occupies a slot.

Optional Feature:
- Macro: ENC_SWC_RANGE_CHECK_EN.
- Defined: the following set inst_err=1 and force word=0:
  - I/S imm outside [-2048,2047].
  - B imm outside [-4096,4094] or imm[0]=1.
  - J imm outside [-1048576,1048574] or imm[0]=1.
  - U imm[11:0]!=0.
  - Shift imm[31:5]!=0.
  - CSR/fence imm[31:12]!=0.
- Undefined: the immediate is silently truncated to its format bits. inst_err reflects illegal op only.

Test Plan:
- addi x1,x0,5 (op 18, rd 1, rs1 0, imm 5) -> one cycle later inst_valid=1, inst_out=0x00500093, inst_err=0, enc_count=1.
- lui x5 (op 0, rd 5, imm 0x12345000) -> 0x123452B7; jal x1,+2048 (op 2, rd 1, imm 0x800) -> 0x001000EF.
- beq x1,x2,-4 (op 4, rs1 1, rs2 2, imm 0xFFFFFFFC) -> 0xFE208EE3.
- DEPTH=2 with inst_ready=0, push sub, ebreak, ecall back-to-back:
  - enc_ready=0 after the 2nd accept; the 3rd request is held.
  - Raise inst_ready -> words 0x40000033-family (per fields), 0x00100073, then 0x00000073, in order; enc_count=3.
- addi imm=2048:
  - With the macro -> inst_err=1, inst_out=0.
  - Without the macro -> inst_out=0x80000093, inst_err=0.
  - op 50 -> inst_err=1, inst_out=0 in both builds.
- Assert hrst with 2 entries queued -> immediately inst_valid=0, enc_count=0, enc_ready=0. After release, enc_ready=1 and the next push appears alone at the head.

Source files
------------

// File: rtl/enc_swc.sv
// RV32I instruction encoder: op index + fields -> 32-bit word, queued in a small output FIFO.
// Define ENC_SWC_RANGE_CHECK_EN to flag out-of-range immediates instead of truncating them.
module enc_swc #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             hclk,
  input  logic             hrst,
  input  logic             enc_valid,
  output logic             enc_ready,
  input  logic [5:0]       enc_op,
  input  logic [4:0]       enc_rd,
  input  logic [4:0]       enc_rs1,
  input  logic [4:0]       enc_rs2,
  input  logic [31:0]      enc_imm,
  output logic [31:0]      inst_out,
  output logic             inst_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [CNT_W-1:0] enc_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_MISC   = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  // FMT_IU is I-type layout with an unsigned 12-bit field (CSR address, fence bits)
  typedef enum logic [3:0] {
    FMT_U, FMT_J, FMT_I, FMT_IU, FMT_SH, FMT_B, FMT_S, FMT_R, FMT_FIX, FMT_ILL
  } fmt_e;

  fmt_e        fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] fix_word;
  logic [31:0] word_raw;
  logic        imm_bad;
  logic        enc_err;
  logic [31:0] enc_word;

  always_comb begin
    fmt      = FMT_ILL;
    opc      = 7'h00;
    f3       = 3'd0;
    f7       = 7'h00;
    fix_word = 32'h0;
    case (enc_op)
      6'd0:  begin fmt = FMT_U;   opc = OPC_LUI;    end
      6'd1:  begin fmt = FMT_U;   opc = OPC_AUIPC;  end
      6'd2:  begin fmt = FMT_J;   opc = OPC_JAL;    end
      6'd3:  begin fmt = FMT_I;   opc = OPC_JALR;   end
      6'd4:  begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = 3'd0; end
      6'd5:  begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = 3'd1; end
      6'd6:  begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = 3'd4; end
      6'd7:  begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = 3'd5; end
      6'd8:  begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = 3'd6; end
      6'd9:  begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = 3'd7; end
      6'd10: begin fmt = FMT_I;   opc = OPC_LOAD;   f3 = 3'd0; end
      6'd11: begin fmt = FMT_I;   opc = OPC_LOAD;   f3 = 3'd1; end
      6'd12: begin fmt = FMT_I;   opc = OPC_LOAD;   f3 = 3'd2; end
      6'd13: begin fmt = FMT_I;   opc = OPC_LOAD;   f3 = 3'd4; end
      6'd14: begin fmt = FMT_I;   opc = OPC_LOAD;   f3 = 3'd5; end
      6'd15: begin fmt = FMT_S;   opc = OPC_STORE;  f3 = 3'd0; end
      6'd16: begin fmt = FMT_S;   opc = OPC_STORE;  f3 = 3'd1; end
      6'd17: begin fmt = FMT_S;   opc = OPC_STORE;  f3 = 3'd2; end
      6'd18: begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = 3'd0; end
      6'd19: begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = 3'd2; end
      6'd20: begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = 3'd3; end
      6'd21: begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = 3'd4; end
      6'd22: begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = 3'd6; end
      6'd23: begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = 3'd7; end
      6'd24: begin fmt = FMT_SH;  opc = OPC_OPIMM;  f3 = 3'd1; end
      6'd25: begin fmt = FMT_SH;  opc = OPC_OPIMM;  f3 = 3'd5; end
      6'd26: begin fmt = FMT_SH;  opc = OPC_OPIMM;  f3 = 3'd5; f7 = 7'h20; end
      6'd27: begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'd0; end
      6'd28: begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'd0; f7 = 7'h20; end
      6'd29: begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'd1; end
      6'd30: begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'd2; end
      6'd31: begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'd3; end
      6'd32: begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'd4; end
      6'd33: begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'd5; end
      6'd34: begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'd5; f7 = 7'h20; end
      6'd35: begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'd6; end
      6'd36: begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'd7; end
      6'd37: begin fmt = FMT_IU;  opc = OPC_MISC;   f3 = 3'd0; end
      6'd38: begin fmt = FMT_FIX; fix_word = 32'h0000100F; end
      6'd39: begin fmt = FMT_FIX; fix_word = 32'h00000073; end
      6'd40: begin fmt = FMT_FIX; fix_word = 32'h00100073; end
      6'd41: begin fmt = FMT_IU;  opc = OPC_SYSTEM; f3 = 3'd1; end
      6'd42: begin fmt = FMT_IU;  opc = OPC_SYSTEM; f3 = 3'd2; end
      6'd43: begin fmt = FMT_IU;  opc = OPC_SYSTEM; f3 = 3'd3; end
      6'd44: begin fmt = FMT_IU;  opc = OPC_SYSTEM; f3 = 3'd5; end
      6'd45: begin fmt = FMT_IU;  opc = OPC_SYSTEM; f3 = 3'd6; end
      6'd46: begin fmt = FMT_IU;  opc = OPC_SYSTEM; f3 = 3'd7; end
      default: fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    word_raw = 32'h0;
    case (fmt)
      FMT_U:   word_raw = {enc_imm[31:12], enc_rd, opc};
      FMT_J:   word_raw = {enc_imm[20], enc_imm[10:1], enc_imm[11], enc_imm[19:12], enc_rd, opc};
      FMT_I,
      FMT_IU:  word_raw = {enc_imm[11:0], enc_rs1, f3, enc_rd, opc};
      FMT_SH:  word_raw = {f7, enc_imm[4:0], enc_rs1, f3, enc_rd, opc};
      FMT_B:   word_raw = {enc_imm[12], enc_imm[10:5], enc_rs2, enc_rs1, f3,
                           enc_imm[4:1], enc_imm[11], opc};
      FMT_S:   word_raw = {enc_imm[11:5], enc_rs2, enc_rs1, f3, enc_imm[4:0], opc};
      FMT_R:   word_raw = {f7, enc_rs2, enc_rs1, f3, enc_rd, opc};
      FMT_FIX: word_raw = fix_word;
      default: word_raw = 32'h0;
    endcase
  end

`ifdef ENC_SWC_RANGE_CHECK_EN
  // A signed field fits when every bit above it matches its sign bit
  logic i_ok, b_ok, j_ok;
  assign i_ok = (&enc_imm[31:11]) | ~(|enc_imm[31:11]);
  assign b_ok = ((&enc_imm[31:12]) | ~(|enc_imm[31:12])) & ~enc_imm[0];
  assign j_ok = ((&enc_imm[31:20]) | ~(|enc_imm[31:20])) & ~enc_imm[0];

  always_comb begin
    imm_bad = 1'b0;
    case (fmt)
      FMT_U:        imm_bad = |enc_imm[11:0];
      FMT_J:        imm_bad = ~j_ok;
      FMT_I, FMT_S: imm_bad = ~i_ok;
      FMT_B:        imm_bad = ~b_ok;
      FMT_SH:       imm_bad = |enc_imm[31:5];
      FMT_IU:       imm_bad = |enc_imm[31:12];
      default:      imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  assign enc_err  = (fmt == FMT_ILL) | imm_bad;
  assign enc_word = enc_err ? 32'h0 : word_raw;

  logic [32:0]      mem_q [DEPTH];
  logic [32:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  assign push = enc_valid & ready_q;
  assign pop  = inst_valid & inst_ready;

  // ready is taken from the next occupancy so a pop while full only frees a slot next cycle
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push);
    occ_d    = occ_q;
    if (push) mem_d[wr_ptr_q] = {enc_err, enc_word};
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    ready_d = (occ_d != OCC_FULL);
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
    end
  end

  assign enc_ready  = ready_q;
  assign enc_count  = cnt_q;
  assign inst_valid = (occ_q != '0);
  assign inst_out   = inst_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
  assign inst_err   = inst_valid & mem_q[rd_ptr_q][32];

endmodule
